// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
//   Bus bundle for the multi-port register file: two byte-enabled write ports
//   and NRD packed read ports.
//
//   Write port n (n = 0, 1):
//     WRn  write enable
//     RWn  write address
//     DWn  write data
//     BEn  byte enables, one bit per data byte
//   Read ports:
//     RA   packed read addresses, port k at [k*AW +: AW]
//     DA   packed read data,      port k at [k*W  +: W]
//
//   Modports: master drives writes and read addresses; slave is the register
//   file and drives DA.
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
  parameter int W   = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);

  logic              WR0;
  logic [AW-1:0]     RW0;
  logic [W-1:0]      DW0;
  logic [W/8-1:0]    BE0;

  logic              WR1;
  logic [AW-1:0]     RW1;
  logic [W-1:0]      DW1;
  logic [W/8-1:0]    BE1;

  logic [NRD*AW-1:0] RA;
  logic [NRD*W-1:0]  DA;

  modport master (
    output WR0, RW0, DW0, BE0,
    output WR1, RW1, DW1, BE1,
    output RA,
    input  DA
  );

  modport slave (
    input  WR0, RW0, DW0, BE0,
    input  WR1, RW1, DW1, BE1,
    input  RA,
    output DA
  );

endinterface

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port register file with two byte-enabled write ports
//   and NRD independent read ports.
//
//   Ports:
//     HCLK     clock, all state updates on the rising edge
//     HRESETn  synchronous active-low clear of every entry (and registered DA)
//     bus      regfile_mp_if.slave: WR0/RW0/DW0/BE0, WR1/RW1/DW1/BE1, RA, DA
//
//   Behaviour summary:
//     - Port 1 wins any byte both ports write in the same cycle.
//     - Writes to addresses >= DEPTH are dropped; such reads return 0.
//     - ZERO_REG=1: entry 0 ignores writes and always reads 0.
//     - READ_REG=0: combinational reads, optionally with write-through bypass.
//     - READ_REG=1: reads registered, write-first (post-write value captured).
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int W        = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  regfile_mp_if.slave  bus
);

  localparam int NB = W / 8;

  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] hit0;
  logic [DEPTH-1:0] hit1;
  logic [AW-1:0]    ra       [NRD];
  logic [NRD-1:0]   ra_ok;
  logic [W-1:0]     rd_store [NRD];
  logic [W-1:0]     rd_merge [NRD];

  // Per-entry write decode. Out-of-range addresses never match an entry, and
  // entry 0 is excluded entirely when it is hardwired to zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    hit0 = '0;
    hit1 = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (!(ZERO_REG != 0 && e == 0)) begin
        hit0[e] = bus.WR0 && (bus.RW0 == AW'(e));
        hit1[e] = bus.WR1 && (bus.RW1 == AW'(e));
      end
    end
  end

  // Storage. Collisions resolve per byte: a port-1 byte enable takes the byte,
  // otherwise port 0 may still write it.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      // NOTE: this memory is cleared by reset on purpose (reads must never
      // return X after the first reset), which forces flops rather than a RAM
      // macro; storage without that requirement is normally left unreset.
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int b = 0; b < NB; b++) begin
          // NOTE: state is updated with non-blocking assignments so every
          // flop samples pre-edge values regardless of statement order.
          if (hit1[e] && bus.BE1[b]) begin
            mem[e][8*b +: 8] <= bus.DW1[8*b +: 8];
          end else if (hit0[e] && bus.BE0[b]) begin
            mem[e][8*b +: 8] <= bus.DW0[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      ra[k] = bus.RA[k*AW +: AW];
    end
  end

  // Read path. rd_store is the plain storage value (0 for out-of-range or the
  // hardwired zero entry); rd_merge overlays the same-cycle write data byte by
  // byte and is the write-first value used by both bypass and registered reads.
  // ra_ok gates the overlay so a suppressed address stays 0 on every path.
  always_comb begin
    ra_ok = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_store[k] = '0;
      for (int e = 0; e < DEPTH; e++) begin
        if (!(ZERO_REG != 0 && e == 0) && (ra[k] == AW'(e))) begin
          rd_store[k] = mem[e];
          ra_ok[k]    = 1'b1;
        end
      end
      rd_merge[k] = rd_store[k];
      if (ra_ok[k] && HRESETn) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.WR1 && (bus.RW1 == ra[k]) && bus.BE1[b]) begin
            rd_merge[k][8*b +: 8] = bus.DW1[8*b +: 8];
          end else if (bus.WR0 && (bus.RW0 == ra[k]) && bus.BE0[b]) begin
            rd_merge[k][8*b +: 8] = bus.DW0[8*b +: 8];
          end
        end
      end
    end
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [NRD*W-1:0] da_q;

      always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
          da_q <= '0;
        end else begin
          for (int k = 0; k < NRD; k++) begin
            da_q[k*W +: W] <= rd_merge[k];
          end
        end
      end

      assign bus.DA = da_q;
    end else begin : g_rd_comb
      logic [NRD*W-1:0] da_c;

      always_comb begin
        da_c = '0;
        for (int k = 0; k < NRD; k++) begin
          da_c[k*W +: W] = (BYPASS != 0) ? rd_merge[k] : rd_store[k];
        end
      end

      assign bus.DA = da_c;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Three register-file instances share one stimulus stream:
//     inst 0: DEPTH=24, ZERO_REG=1, BYPASS=1, READ_REG=0
//     inst 1: DEPTH=32, ZERO_REG=0, BYPASS=0, READ_REG=0
//     inst 2: DEPTH=32, ZERO_REG=1, READ_REG=1
//   A behavioural model (array per instance) predicts DA; a compare process
//   checks every read port every cycle, and a directed preamble pins the model
//   with hand-computed values before randomized traffic.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int NI = 3;
  localparam int DEP [NI] = '{24, 32, 32};
  localparam int ZR  [NI] = '{1, 0, 1};
  localparam int BYP [NI] = '{1, 0, 0};
  localparam int REG [NI] = '{0, 0, 1};

  logic        clk;
  logic        rst_n;
  logic        wr0, wr1;
  logic [4:0]  rw0, rw1;
  logic [31:0] dw0, dw1;
  logic [3:0]  be0, be1;
  logic [4:0]  ra0, ra1;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 0;

  logic [31:0] m_mem [NI][32];
  logic [31:0] m_rq  [NI][2];
  logic [63:0] da_all [NI];

  regfile_mp_if #(.W(32), .AW(5), .NRD(2)) bus_a ();
  regfile_mp_if #(.W(32), .AW(5), .NRD(2)) bus_b ();
  regfile_mp_if #(.W(32), .AW(5), .NRD(2)) bus_c ();

  assign bus_a.WR0 = wr0;  assign bus_a.RW0 = rw0;  assign bus_a.DW0 = dw0;  assign bus_a.BE0 = be0;
  assign bus_a.WR1 = wr1;  assign bus_a.RW1 = rw1;  assign bus_a.DW1 = dw1;  assign bus_a.BE1 = be1;
  assign bus_a.RA  = {ra1, ra0};
  assign bus_b.WR0 = wr0;  assign bus_b.RW0 = rw0;  assign bus_b.DW0 = dw0;  assign bus_b.BE0 = be0;
  assign bus_b.WR1 = wr1;  assign bus_b.RW1 = rw1;  assign bus_b.DW1 = dw1;  assign bus_b.BE1 = be1;
  assign bus_b.RA  = {ra1, ra0};
  assign bus_c.WR0 = wr0;  assign bus_c.RW0 = rw0;  assign bus_c.DW0 = dw0;  assign bus_c.BE0 = be0;
  assign bus_c.WR1 = wr1;  assign bus_c.RW1 = rw1;  assign bus_c.DW1 = dw1;  assign bus_c.BE1 = be1;
  assign bus_c.RA  = {ra1, ra0};

  assign da_all[0] = bus_a.DA;
  assign da_all[1] = bus_b.DA;
  assign da_all[2] = bus_c.DA;

  regfile_mp #(.W(32), .DEPTH(DEP[0]), .AW(5), .NRD(2), .ZERO_REG(ZR[0]),
               .BYPASS(BYP[0]), .READ_REG(REG[0]))
    u_a (.HCLK(clk), .HRESETn(rst_n), .bus(bus_a));
  regfile_mp #(.W(32), .DEPTH(DEP[1]), .AW(5), .NRD(2), .ZERO_REG(ZR[1]),
               .BYPASS(BYP[1]), .READ_REG(REG[1]))
    u_b (.HCLK(clk), .HRESETn(rst_n), .bus(bus_b));
  regfile_mp #(.W(32), .DEPTH(DEP[2]), .AW(5), .NRD(2), .ZERO_REG(ZR[2]),
               .BYPASS(BYP[2]), .READ_REG(REG[2]))
    u_c (.HCLK(clk), .HRESETn(rst_n), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit addr_ok(int i, logic [4:0] a);
    return (int'(a) < DEP[i]) && !(ZR[i] == 1 && a == 5'd0);
  endfunction

  // What a read of address a returns right now: 0 when suppressed, otherwise
  // stored word with this cycle's write data overlaid when merge is set.
  function automatic logic [31:0] model_read(int i, logic [4:0] a, bit merge);
    logic [31:0] v;
    if (!addr_ok(i, a)) return 32'h0;
    v = m_mem[i][a];
    if (merge) begin
      for (int b = 0; b < 4; b++) begin
        if (wr1 && rw1 == a && be1[b])      v[8*b +: 8] = dw1[8*b +: 8];
        else if (wr0 && rw0 == a && be0[b]) v[8*b +: 8] = dw0[8*b +: 8];
      end
    end
    return v;
  endfunction

  // Model state update at the edge; port 1's assignments come last so they
  // take any byte both ports write.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        for (int e = 0; e < 32; e++) m_mem[i][e] <= 32'h0;
        m_rq[i][0] <= 32'h0;
        m_rq[i][1] <= 32'h0;
      end
      started <= 1'b1;
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_rq[i][0] <= model_read(i, ra0, 1'b1);
        m_rq[i][1] <= model_read(i, ra1, 1'b1);
        for (int b = 0; b < 4; b++) begin
          if (wr0 && be0[b] && addr_ok(i, rw0)) m_mem[i][rw0][8*b +: 8] <= dw0[8*b +: 8];
          if (wr1 && be1[b] && addr_ok(i, rw1)) m_mem[i][rw1][8*b +: 8] <= dw1[8*b +: 8];
        end
      end
    end
  end

  // Compare process: every port of every instance, each cycle, late in the
  // low phase after stimulus has settled.
  always @(negedge clk) begin
    #3;
    if (started) begin
      for (int i = 0; i < NI; i++) begin
        for (int k = 0; k < 2; k++) begin
          logic [31:0] exp;
          if (REG[i] == 1) exp = m_rq[i][k];
          else             exp = model_read(i, (k == 0) ? ra0 : ra1, (BYP[i] == 1) && rst_n);
          check($sformatf("cmp inst%0d port%0d t=%0t", i, k, $time),
                da_all[i][k*32 +: 32], exp);
        end
      end
    end
  end

  task automatic idle();
    wr0 = 1'b0; rw0 = '0; dw0 = '0; be0 = '0;
    wr1 = 1'b0; rw1 = '0; dw1 = '0; be1 = '0;
  endtask

  task automatic w0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr0 = 1'b1; rw0 = a; dw0 = d; be0 = be;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] port0(int i);
    return da_all[i][31:0];
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    ra0 = 5'd5;
    ra1 = 5'd10;

    // Reset at the first edge, then every port of every instance reads 0.
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset inst%0d p0", i), da_all[i][31:0], 32'h0);
      check($sformatf("reset inst%0d p1", i), da_all[i][63:32], 32'h0);
    end

    // Full-word write to entry 5.
    w0(5'd5, 32'h64, 4'hF);
    tick();
    for (int i = 0; i < NI; i++) check($sformatf("wr5 inst%0d", i), port0(i), 32'h00000064);

    // Byte-enable collision on entry 20.
    idle();
    w0(5'd20, 32'hFFFB6BC2, 4'hF);
    tick();
    w0(5'd20, 32'h11223344, 4'hF);
    wr1 = 1'b1; rw1 = 5'd20; dw1 = 32'hAABBCCDD; be1 = 4'b0101;
    ra0 = 5'd20;
    #1;
    check("collision bypass pre-edge", port0(0), 32'h11BB33DD);
    tick();
    for (int i = 0; i < NI; i++) check($sformatf("collision inst%0d", i), port0(i), 32'h11BB33DD);

    // Entry 0: hardwired zero on inst 0/2, ordinary on inst 1.
    idle();
    w0(5'd0, 32'hDEADBEEF, 4'hF);
    ra0 = 5'd0;
    #1;
    check("zero bypass pre-edge", port0(0), 32'h0);
    tick();
    check("zero inst0", port0(0), 32'h0);
    check("zero inst1", port0(1), 32'hDEADBEEF);
    check("zero inst2", port0(2), 32'h0);

    // Address 30 is out of range for the 24-entry instance.
    idle();
    w0(5'd30, 32'h12345678, 4'hF);
    ra0 = 5'd30;
    ra1 = 5'd6;
    tick();
    check("range inst0 rd30", port0(0), 32'h0);
    check("range inst0 rd6", da_all[0][63:32], 32'h0);
    check("range inst1 rd30", port0(1), 32'h12345678);

    // Bypass versus plain combinational read.
    idle();
    w0(5'd7, 32'h11, 4'hF);
    ra0 = 5'd3;
    tick();
    ra0 = 5'd7;
    w0(5'd7, 32'h383, 4'hF);
    #1;
    check("bypass pre-edge inst0", port0(0), 32'h383);
    check("nobypass pre-edge inst1", port0(1), 32'h11);
    tick();
    check("nobypass post-edge inst1", port0(1), 32'h383);

    // Registered read latency and write-first behaviour.
    idle();
    w0(5'd10, 32'hC8, 4'hF);
    ra0 = 5'd1;
    tick();
    idle();
    ra0 = 5'd10;
    #1;
    check("regread before edge", port0(2), 32'h0);
    tick();
    check("regread after edge", port0(2), 32'hC8);
    w0(5'd10, 32'h55, 4'hF);
    tick();
    check("regread write-first", port0(2), 32'h55);

    // Reset in the middle of traffic wins over a same-edge write.
    idle();
    w0(5'd3, 32'h77, 4'hF);
    ra0 = 5'd3;
    tick();
    rst_n = 1'b0;
    w0(5'd3, 32'h99, 4'hF);
    tick();
    for (int i = 0; i < NI; i++) check($sformatf("midreset inst%0d", i), port0(i), 32'h0);
    rst_n = 1'b1;
    w0(5'd3, 32'hAB, 4'hF);
    tick();
    check("resume inst1", port0(1), 32'hAB);
    check("resume inst2", port0(2), 32'hAB);

    // Randomized traffic, occasionally reset; the compare process checks it.
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      wr0 = ($urandom_range(0, 3) != 0);
      rw0 = 5'($urandom_range(0, 31));
      dw0 = $urandom;
      be0 = 4'($urandom);
      wr1 = ($urandom_range(0, 2) != 0);
      rw1 = ($urandom_range(0, 3) == 0) ? rw0 : 5'($urandom_range(0, 31));
      dw1 = $urandom;
      be1 = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       ra0 = rw0;
        1:       ra0 = rw1;
        default: ra0 = 5'($urandom_range(0, 31));
      endcase
      ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom_range(0, 31));
      tick();
    end

    rst_n = 1'b1;
    idle();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
